// File: rtl/mul_iter.sv
// Iterative DIGITxDIGIT multiplier for the execute stage: one partial product per cycle,
// all four signedness modes, low/high result half, stall support and a one-entry result cache.
module mul_iter #(
  parameter int WIDTH    = 32,
  parameter int DIGIT    = 16,  // must divide WIDTH
  parameter int CACHE_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] first_operand_i,
  input  logic [WIDTH-1:0] second_operand_i,
  input  logic [1:0]       signed_mode_i,
  input  logic             mul_low_i,
  output logic             hold_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_SIGN
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [1:0]           mode_q, mode_d;
  logic                 low_q, low_d;
  logic [WIDTH-1:0]     a_mag_q, a_mag_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]     i_q, i_d;
  logic [IDX_W-1:0]     j_q, j_d;
  logic                 hold_q, hold_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cache_valid_q, cache_valid_d;
  logic                 cache_full_q, cache_full_d;
  logic [WIDTH-1:0]     cache_a_q, cache_a_d;
  logic [WIDTH-1:0]     cache_b_q, cache_b_d;
  logic [1:0]           cache_mode_q, cache_mode_d;
  logic [2*WIDTH-1:0]   cache_prod_q, cache_prod_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    // The most negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  // Partial-product datapath for the current digit pair.
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [2*WIDTH-1:0] pp_ext, pp_shift, prod_final;
  logic               j_done, i_done, cache_hit;
  int                 j_last;

  always_comb begin
    a_sh     = a_mag_q >> (int'(i_q) * DIGIT);
    b_sh     = b_mag_q >> (int'(j_q) * DIGIT);
    a_dig    = a_sh[DIGIT-1:0];
    b_dig    = b_sh[DIGIT-1:0];
    pp       = {{DIGIT{1'b0}}, a_dig} * {{DIGIT{1'b0}}, b_dig};
    pp_ext   = '0;
    pp_ext[2*DIGIT-1:0] = pp;
    pp_shift = pp_ext << ((int'(i_q) + int'(j_q)) * DIGIT);
    // Low requests only need pairs with i+j < N; the rest land entirely in the upper half.
    j_last   = low_q ? (N - 1 - int'(i_q)) : (N - 1);
    j_done   = (int'(j_q) == j_last);
    i_done   = (int'(i_q) == N - 1);
    prod_final = neg_q ? -acc_q : acc_q;
    cache_hit  = (CACHE_EN != 0) && cache_valid_q
                 && (first_operand_i == cache_a_q) && (second_operand_i == cache_b_q)
                 && (signed_mode_i == cache_mode_q) && (cache_full_q || mul_low_i);
  end

  always_comb begin
    // NOTE: every _d signal takes its _q value first, so no path through this block can infer a latch.
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    mode_d       = mode_q;
    low_d        = low_q;
    a_mag_d      = a_mag_q;
    b_mag_d      = b_mag_q;
    neg_d        = neg_q;
    acc_d        = acc_q;
    i_d          = i_q;
    j_d          = j_q;
    valid_d      = 1'b0;
    result_d     = result_q;
    cache_valid_d = cache_valid_q;
    cache_full_d  = cache_full_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_mode_d  = cache_mode_q;
    cache_prod_d  = cache_prod_q;

    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            a_d    = first_operand_i;
            b_d    = second_operand_i;
            mode_d = signed_mode_i;
            low_d  = mul_low_i;
            if (cache_hit) begin
              result_d = mul_low_i ? cache_prod_q[WIDTH-1:0] : cache_prod_q[2*WIDTH-1:WIDTH];
              valid_d  = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          a_mag_d = magnitude(a_q, mode_q[0]);
          b_mag_d = magnitude(b_q, mode_q[1]);
          neg_d   = (mode_q[0] & a_q[WIDTH-1]) ^ (mode_q[1] & b_q[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_ACC;
        end
        S_ACC: begin
          acc_d = acc_q + pp_shift;
          if (j_done) begin
            j_d = '0;
            if (i_done) state_d = S_SIGN;
            else        i_d = i_q + IDX_W'(1);
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
        S_SIGN: begin
          acc_d    = prod_final;
          result_d = low_q ? prod_final[WIDTH-1:0] : prod_final[2*WIDTH-1:WIDTH];
          valid_d  = 1'b1;
          state_d  = S_IDLE;
          if (CACHE_EN != 0) begin
            cache_valid_d = 1'b1;
            cache_full_d  = !low_q;
            cache_a_d     = a_q;
            cache_b_d     = b_q;
            cache_mode_d  = mode_q;
            cache_prod_d  = prod_final;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    hold_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state is written only here, with non-blocking assignments, so every flop
  // samples the values computed before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      mode_q        <= '0;
      low_q         <= 1'b0;
      a_mag_q       <= '0;
      b_mag_q       <= '0;
      neg_q         <= 1'b0;
      acc_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      hold_q        <= 1'b0;
      valid_q       <= 1'b0;
      result_q      <= '0;
      // NOTE: only cache_valid_q must be cleared for correctness; the cache payload is reset
      // too because it is a single entry and keeps every flop in one async-reset block.
      cache_valid_q <= 1'b0;
      cache_full_q  <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_mode_q  <= '0;
      cache_prod_q  <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      mode_q        <= mode_d;
      low_q         <= low_d;
      a_mag_q       <= a_mag_d;
      b_mag_q       <= b_mag_d;
      neg_q         <= neg_d;
      acc_q         <= acc_d;
      i_q           <= i_d;
      j_q           <= j_d;
      hold_q        <= hold_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
      cache_valid_q <= cache_valid_d;
      cache_full_q  <= cache_full_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_mode_q  <= cache_mode_d;
      cache_prod_q  <= cache_prod_d;
    end
  end

  assign hold_o   = hold_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Parametrised iterative multiplier; successor to the fixed 32-bit multi-cycle multiplier used by the execute stage.
- Splits each operand into DIGIT-bit digits and accumulates one DIGIT×DIGIT partial product per cycle.
- Supports all four signedness modes, low or high result half, and pipeline stall.
- New over its predecessor: width/digit parametrisation, early-out for low-half requests, and a one-entry result cache that answers repeated operations in one cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 16, digit width; must divide WIDTH. N = WIDTH/DIGIT.
- CACHE_EN, 1, 1 enables the result cache; 0 means every request misses.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freezes all internal state and blocks request acceptance.
- enable_i  in  1  request strobe, sampled only in IDLE with stall=0.
- first_operand_i  in  WIDTH  operand A.
- second_operand_i  in  WIDTH  operand B.
- signed_mode_i  in  2  bit0=1: A signed; bit1=1: B signed (00 uu, 01 su, 10 us, 11 ss).
- mul_low_i  in  1  1 returns product[WIDTH-1:0]; 0 returns product[2*WIDTH-1:WIDTH].
- hold_o  out  1  registered; 1 in every state except IDLE.
- valid_o  out  1  registered one-cycle pulse when result_o updates.
- result_o  out  WIDTH  registered result; holds its value until the next completion.

Behaviour:
- Reset (asynchronous): state=IDLE, hold_o=0, valid_o=0, result_o=0, accumulator=0, pair counter=0, cache invalid.
- Accept (edge E0, IDLE, enable_i=1, stall=0):
  - Latch operands, mode and mul_low_i.
  - Cache hit: CACHE_EN=1, cache valid, operands and mode equal to the cached entry, and (cached entry full, or request is low).
  - On hit: at E0 result_o takes the selected half of the cached product, valid_o=1, state stays IDLE, hold_o stays 0. Latency 1.
  - On miss: go to LOAD.
- LOAD (1 cycle):
  - Capture |A| and |B| as unsigned WIDTH-bit magnitudes; the most negative value maps to 2^(WIDTH-1).
  - neg = (A signed and A[msb]) XOR (B signed and B[msb]).
  - Clear the 2*WIDTH accumulator. Go to ACC.
- ACC (1 cycle per pair):
  - Visits digit pairs (i,j) with i outer and j inner, both 0..N-1.
  - When mul_low: pairs with i+j >= N are skipped with no cycle cost.
  - Each cycle: acc += (|A|digit_i × |B|digit_j) << ((i+j)*DIGIT), modulo 2^(2*WIDTH).
  - P = N*N for high requests; P = N(N+1)/2 for low. With defaults, P = 4 (high) or 3 (low).
  - Go to SIGN after the last pair.
- SIGN (1 cycle): acc = neg ? -acc : acc (two's complement over 2*WIDTH).
- Completion edge:
  - result_o = selected half; valid_o=1; state=IDLE.
  - Cache updates with operands, mode, acc, and a full flag = !mul_low.
- Miss latency: P+2 cycles from E0 to valid_o; hold_o is high for P+2 cycles. Defaults: low 5, high 6.
- stall=1:
  - State, counter, accumulator and outputs are frozen; valid_o is forced 0 while stall=1.
  - A completion due under stall is deferred until stall falls.
  - enable_i is ignored in IDLE while stalled.
- enable_i while hold_o=1: ignored; no queueing.
- Operand or mode changes after E0 have no effect on the operation in flight.
- Reset mid-operation: aborts immediately to reset values; the cache is invalidated.
- No divide-by-zero or overflow flags; the product is exact in 2*WIDTH bits.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> hold_o=0, valid_o=0, result_o=0 immediately.
- Unsigned low: A=65535, B=65535, mode 00, low -> result_o=0xFFFE0001; valid_o 5 cycles after E0; hold_o high exactly 5 cycles.
- Signed:
  - A=-7, B=8, mode 11, high -> 0xFFFFFFFF in 6 cycles.
  - Same operands, low -> 0xFFFFFFC8.
  - A=0x80000000, B=0x80000000, mode 11, high -> 0x40000000.
- Mixed modes:
  - A=0xFFFFFFFF, B=0xFFFFFFFF, mode 01, high -> 0xFFFFFFFF; low -> 0x00000001.
  - A=3, B=0xFFFFFFFE, mode 10, low -> 0xFFFFFFFA.
- Cache:
  - Repeat A=1000, B=1000, mode 00, high after a full op -> valid_o 1 cycle after E0, hold_o stays 0, result_o=0.
  - Same operands, low -> hit, 0x000F4240.
  - Low op, then same operands high -> miss, 6 cycles.
  - Mode change -> miss.
  - CACHE_EN=0 -> all requests miss.
- Stall and reset:
  - stall held 3 cycles during ACC of 10×3 low -> valid_o at cycle 8, result_o=0x1E.
  - stall at completion -> no valid_o until release.
  - enable_i during busy -> ignored.
  - reset during ACC, then identical request -> misses; correct result after full latency.
